// File: rtl/rgb_mixer_pkg.sv
// Shared constants, step encoding and the saturating/wrapping level update
// for the multi-channel encoder-to-PWM mixer.
package rgb_mixer_pkg;

    localparam int DEF_NUM_CH       = 3;
    localparam int DEF_WIDTH        = 8;
    localparam int DEF_DEBOUNCE_LEN = 4;
    localparam int MAX_WIDTH        = 12;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2
    } step_t;

    // Levels are carried at MAX_WIDTH; width selects the live range.
    function automatic logic [MAX_WIDTH-1:0] apply_step(
        input logic [MAX_WIDTH-1:0] lvl,
        input step_t                step,
        input int unsigned          width,
        input logic                 sat
    );
        logic [MAX_WIDTH-1:0] top_v;
        logic [MAX_WIDTH-1:0] res;
        top_v = MAX_WIDTH'((32'd1 << width) - 32'd1);
        case (step)
            STEP_UP: res = (sat && lvl == top_v) ? lvl : ((lvl + 1'b1) & top_v);
            STEP_DN: res = (sat && lvl == '0)    ? lvl : ((lvl - 1'b1) & top_v);
            default: res = lvl;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rgb_mixer_multi_enc_channel.sv
// One encoder channel: 2-FF synchronisers, debouncers for A and B,
// rising-A quadrature decoder and the level register.
module enc_channel
    import rgb_mixer_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEBOUNCE_LEN = DEF_DEBOUNCE_LEN,
    parameter int SATURATE     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a_i,
    input  logic             enc_b_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] level_o
);

    localparam int CNT_W = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_LEN - 1);

    logic [1:0]       raw;
    logic             sync1_q [2];
    logic             sync2_q [2];
    logic             deb_q   [2];
    logic             deb_d   [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];

    assign raw = {enc_b_i, enc_a_i};

    // Index 0 is phase A, index 1 is phase B.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            always_comb begin
                deb_d[gi] = deb_q[gi];
                cnt_d[gi] = '0;
                if (sync2_q[gi] != deb_q[gi]) begin
                    if (cnt_q[gi] == CNT_TOP) begin
                        deb_d[gi] = sync2_q[gi];
                    end else begin
                        cnt_d[gi] = cnt_q[gi] + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q[gi] <= 1'b0;
                    sync2_q[gi] <= 1'b0;
                    deb_q[gi]   <= 1'b0;
                    cnt_q[gi]   <= '0;
                end else begin
                    sync1_q[gi] <= raw[gi];
                    sync2_q[gi] <= sync1_q[gi];
                    deb_q[gi]   <= deb_d[gi];
                    cnt_q[gi]   <= cnt_d[gi];
                end
            end
        end
    endgenerate

    logic             deb_a_prev_q;
    step_t            step_q;
    step_t            step_d;
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;

    always_comb begin
        step_d = STEP_NONE;
        if (deb_q[0] && !deb_a_prev_q) begin
            step_d = deb_q[1] ? STEP_DN : STEP_UP;
        end
    end

    // A load overrides the step that would land in the same cycle.
    always_comb begin
        if (load_i) begin
            level_d = load_value_i;
        end else begin
            level_d = WIDTH'(apply_step(MAX_WIDTH'(level_q), step_q, WIDTH, SATURATE != 0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_a_prev_q <= 1'b0;
            step_q       <= STEP_NONE;
            level_q      <= '0;
        end else begin
            deb_a_prev_q <= deb_q[0];
            step_q       <= step_d;
            level_q      <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/rgb_mixer_multi.sv
// NUM_CH encoder channels feeding a shared-timebase PWM bank.
// Define RGB_MIXER_LOAD_EN to add direct level-load ports.
module rgb_mixer_multi
    import rgb_mixer_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEBOUNCE_LEN = DEF_DEBOUNCE_LEN,
    parameter int SATURATE     = 1,
    localparam int LCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
`ifdef RGB_MIXER_LOAD_EN
    input  logic                    load_valid,
    input  logic [LCH_W-1:0]        load_ch,
    input  logic [WIDTH-1:0]        load_value,
`endif
    output logic [NUM_CH-1:0]       pwm_out,
    output logic [NUM_CH*WIDTH-1:0] level_out
);

    localparam logic [WIDTH-1:0] PCNT_TOP = '1;

    logic             load_hit [NUM_CH];
    logic [WIDTH-1:0] load_val;

`ifdef RGB_MIXER_LOAD_EN
    assign load_val = load_value;
`else
    assign load_val = '0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
`ifdef RGB_MIXER_LOAD_EN
            assign load_hit[gi] = load_valid && (load_ch == LCH_W'(gi));
`else
            assign load_hit[gi] = 1'b0;
`endif
            enc_channel #(
                .WIDTH        (WIDTH),
                .DEBOUNCE_LEN (DEBOUNCE_LEN),
                .SATURATE     (SATURATE)
            ) u_ch (
                .clk          (clk),
                .reset        (reset),
                .enc_a_i      (enc_a[gi]),
                .enc_b_i      (enc_b[gi]),
                .load_i       (load_hit[gi]),
                .load_value_i (load_val),
                .level_o      (level_out[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

    logic [WIDTH-1:0]  pcnt_q;
    logic [WIDTH-1:0]  pcnt_d;
    logic [WIDTH-1:0]  shadow_q [NUM_CH];
    logic [NUM_CH-1:0] pwm_q;

    assign pcnt_d = pcnt_q + 1'b1;

    // Shadow reloads only on the last count so duty changes land on a period boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
            pwm_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            pcnt_q <= pcnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (pcnt_q == PCNT_TOP) begin
                    shadow_q[i] <= level_out[i*WIDTH +: WIDTH];
                end
                pwm_q[i] <= (pcnt_q < shadow_q[i]);
            end
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_rgb_mixer_multi.sv
// Directed bench: saturating 3-channel mixer plus a 1-channel wrapping instance,
// scoreboarded level checks and period-aligned PWM duty measurement.
module tb_rgb_mixer_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  enc_a;
    logic [3:0]  enc_b;
    wire  [2:0]  pwm_out;
    wire  [23:0] level_out;
    wire  [0:0]  w_pwm;
    wire  [7:0]  w_level;
`ifdef RGB_MIXER_LOAD_EN
    logic        load_valid;
    logic [1:0]  load_ch;
    logic [7:0]  load_value;
`endif

    always #5 clk = ~clk;

    rgb_mixer_multi #(.NUM_CH(3), .WIDTH(8), .DEBOUNCE_LEN(4), .SATURATE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .enc_a      (enc_a[2:0]),
        .enc_b      (enc_b[2:0]),
`ifdef RGB_MIXER_LOAD_EN
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_value (load_value),
`endif
        .pwm_out    (pwm_out),
        .level_out  (level_out)
    );

    rgb_mixer_multi #(.NUM_CH(1), .WIDTH(8), .DEBOUNCE_LEN(4), .SATURATE(0)) dut_wrap (
        .clk        (clk),
        .reset      (reset),
        .enc_a      (enc_a[3:3]),
        .enc_b      (enc_b[3:3]),
`ifdef RGB_MIXER_LOAD_EN
        .load_valid (1'b0),
        .load_ch    (1'b0),
        .load_value (8'd0),
`endif
        .pwm_out    (w_pwm),
        .level_out  (w_level)
    );

    // Model of the PWM counter value after each edge.
    logic [7:0] pc;
    always @(posedge clk) pc <= reset ? 8'd0 : pc + 8'd1;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [23:0] lvl;
        logic [7:0]  w;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] exp_lvl;
    logic [7:0]  exp_w;
    logic [3:0]  pwm_all;

    assign pwm_all = {w_pwm, pwm_out};

    function automatic logic [7:0] model_step(input logic [7:0] v, input logic up, input logic sat);
        if (up) return (sat && v == 8'hFF) ? v : v + 8'd1;
        else    return (sat && v == 8'h00) ? v : v - 8'd1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.lvl = exp_lvl;
        e.w   = exp_w;
        sb.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_lvl"},  {8'd0, level_out}, {8'd0, e.lvl});
            check({tag, "_wrap"}, {24'd0, w_level},  {24'd0, e.w});
        end
    endtask

    // Set B, let it settle, then pulse A on every channel in m for hi cycles.
    task automatic pulse(input logic [3:0] m, input logic [3:0] b, input int hi);
        enc_b = b;
        tick(8);
        enc_a = m;
        tick(hi);
        enc_a = 4'b0000;
        tick(8);
        if (hi >= 4) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (m[ch]) exp_lvl[ch*8 +: 8] = model_step(exp_lvl[ch*8 +: 8], !b[ch], 1'b1);
            end
            if (m[3]) exp_w = model_step(exp_w, !b[3], 1'b0);
        end
        push_exp();
    endtask

    // Count high cycles over one full period, starting where pc says a period begins.
    task automatic measure(input int ch, output int highs);
        int k;
        k = 0;
        while (pc != 8'd1 && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (k >= 600) check("period_align_timeout", 32'd1, 32'd0);
        highs = 0;
        repeat (256) begin
            if (pwm_all[ch]) highs++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_lvl = '0;
        exp_w   = '0;
    endtask

    initial begin
        int n;
        int h1;
        int h2;
        enc_a = '0;
        enc_b = '0;
`ifdef RGB_MIXER_LOAD_EN
        load_valid = 1'b0;
        load_ch    = '0;
        load_value = '0;
`endif
        reset = 1'b1;
        tick(3);
        do_reset();
        check("reset_level", {8'd0, level_out}, 32'd0);
        check("reset_pwm",   {29'd0, pwm_out},  32'd0);
        check("reset_wrap",  {24'd0, w_level},  32'd0);

        // Latency of the first clean A rise on ch0.
        enc_a[0] = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (level_out[7:0] == 8'd0 && n < 50);
        check("latency_edges", n, 32'd8);
        tick(4);
        enc_a = '0;
        tick(8);
        exp_lvl[7:0] = 8'd1;
        push_exp();
        check_sb("first_pulse");
        for (int i = 0; i < 4; i++) begin
            pulse(4'b0001, 4'b0000, 6);
            check_sb("ch0_up");
        end

        // Wrapping instance: 0 - 1 -> 255, then 255 + 1 -> 0.
        pulse(4'b1000, 4'b1000, 6);
        check_sb("wrap_down");
        pulse(4'b1000, 4'b0000, 6);
        check_sb("wrap_up");

        // Saturation at both ends on ch1.
        pulse(4'b0010, 4'b0010, 6);
        check_sb("ch1_floor");
        for (int i = 0; i < 255; i++) begin
            pulse(4'b0010, 4'b0000, 6);
            check_sb("ch1_climb");
        end
        pulse(4'b0010, 4'b0000, 6);
        check_sb("ch1_ceiling");
        measure(1, h1);
        check("pwm_level255_highs", h1, 32'd255);

        // Glitch rejection on ch2.
        pulse(4'b0100, 4'b0000, 3);
        check_sb("ch2_glitch3");
        pulse(4'b0100, 4'b0000, 4);
        check_sb("ch2_stable4");

        // Duty cycle on ch0, then a change landing mid-period.
        for (int i = 0; i < 59; i++) begin
            pulse(4'b0001, 4'b0000, 6);
            check_sb("ch0_to64");
        end
        measure(0, h1);
        check("pwm_level64_highs", h1, 32'd64);
        fork
            measure(0, h1);
            begin
                tick(40);
                pulse(4'b0001, 4'b0000, 6);
            end
        join
        check("pwm_midperiod_old_duty", h1, 32'd64);
        check_sb("ch0_to65");
        measure(0, h2);
        check("pwm_next_period_duty", h2, 32'd65);

        // Level 0 gives constant low.
        do_reset();
        measure(0, h1);
        check("pwm_level0_highs", h1, 32'd0);

        // Simultaneous steps, then reset mid-debounce.
        for (int i = 0; i < 10; i++) begin
            pulse(4'b0111, 4'b0000, 6);
            check_sb("build_10_20_30");
        end
        for (int i = 0; i < 10; i++) begin
            pulse(4'b0110, 4'b0000, 6);
            check_sb("build_10_20_30");
        end
        for (int i = 0; i < 10; i++) begin
            pulse(4'b0100, 4'b0000, 6);
            check_sb("build_10_20_30");
        end
        check("levels_10_20_30", {8'd0, level_out}, {8'd0, 8'd30, 8'd20, 8'd10});
        enc_a[0] = 1'b1;
        tick(3);
        reset = 1'b1;
        enc_a = '0;
        tick(1);
        reset = 1'b0;
        check("midrun_reset_level", {8'd0, level_out}, 32'd0);
        check("midrun_reset_pwm",   {29'd0, pwm_out},  32'd0);
        tick(20);
        check("inflight_edge_lost", {8'd0, level_out}, 32'd0);
        exp_lvl = '0;
        exp_w   = '0;

`ifdef RGB_MIXER_LOAD_EN
        // Load coincident with an up-step on ch1 wins; out-of-range channel ignored.
        enc_b = '0;
        tick(8);
        enc_a[1] = 1'b1;
        tick(7);
        load_valid = 1'b1;
        load_ch    = 2'd1;
        load_value = 8'd200;
        tick(1);
        load_valid = 1'b0;
        tick(4);
        enc_a = '0;
        tick(8);
        exp_lvl[15:8] = 8'd200;
        push_exp();
        check_sb("load_priority");
        load_valid = 1'b1;
        load_ch    = 2'd3;
        load_value = 8'd77;
        tick(1);
        load_valid = 1'b0;
        tick(2);
        push_exp();
        check_sb("load_out_of_range");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rgb_mixer_multi.md
Name: rgb_mixer_multi

Overview:
- Parametrised successor to the three-channel encoder-to-PWM mixer.
- NUM_CH rotary quadrature encoders each set a WIDTH-bit level.
- Each channel has its own synchroniser, debouncer, decoder and level counter; one shared PWM timebase drives all NUM_CH PWM outputs.
- Instantiated inside the user-project wrapper: encoders come from io_in, PWM goes to io_out, reset comes from a logic-analyser bit.

Parameters:
- NUM_CH, 3, number of encoder/PWM channels (1..8).
- WIDTH, 8, level counter and PWM resolution in bits (4..12).
- DEBOUNCE_LEN, 4, consecutive stable samples needed before a debounced input changes (2..255).
- SATURATE, 1, 1 = level clamps at 0 and 2^WIDTH-1; 0 = level wraps modulo 2^WIDTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enc_a  input  NUM_CH  encoder A phases, asynchronous.
- enc_b  input  NUM_CH  encoder B phases, asynchronous.
- pwm_out  output  NUM_CH  PWM outputs, registered.
- level_out  output  NUM_CH*WIDTH  current levels; channel i occupies bits [i*WIDTH +: WIDTH].

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On any clk edge with reset=1, all state clears: synchronisers, debounce counters, debounced values, levels, shadow levels, PWM counter and pwm_out all go to 0. This applies mid-operation too; a pending debounce count is discarded.
- Synchroniser: 2-FF per enc_a/enc_b bit.
- Debounce, per input:
  - While the synced value equals the debounced value, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_LEN-1 and the values still differ, the debounced value takes the synced value and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_LEN cycles never propagates.
- Decode: on a rising edge of debounced A, step is +1 if debounced B=0 and -1 if debounced B=1. Falling A and any B edge produce no step.
- Level update: on the cycle after the decode edge.
  - SATURATE=1: 2^WIDTH-1 plus +1 stays at 2^WIDTH-1; 0 minus 1 stays at 0.
  - SATURATE=0: wraps in both directions.
- Latency: a clean A rise, held with B stable, appears on level_out exactly DEBOUNCE_LEN+4 clk edges after the first edge that samples it.
- PWM timebase: WIDTH-bit counter pcnt, incrementing every cycle and wrapping from 2^WIDTH-1 to 0.
- Shadow level: loaded from level on the cycle pcnt==2^WIDTH-1, so the duty cycle changes only at a period boundary (glitch-free).
- PWM output: pwm_out[i] is registered as (pcnt < shadow[i]).
  - Period is 2^WIDTH cycles; high time is shadow[i] cycles.
  - Level 0 gives constant low; level 2^WIDTH-1 gives low for 1 cycle per period.
- Channel independence: simultaneous steps on different channels are all applied in the same cycle.

Optional Feature:
- Macro: RGB_MIXER_LOAD_EN.
- Defined: adds input ports load_valid (1), load_ch ($clog2(NUM_CH), minimum width 1) and load_value (WIDTH).
  - When load_valid=1 and load_ch<NUM_CH, level[load_ch] takes load_value on the next edge.
  - A load has priority over an encoder step on the same channel in the same cycle; that step is dropped.
  - load_ch>=NUM_CH is ignored.
  - The shadow level still updates only at the period boundary.
- Undefined: these ports do not exist and levels change only via the encoders.

Decomposition:
- Package rgb_mixer_pkg holds:
  - default parameter constants (DEF_NUM_CH, DEF_WIDTH, DEF_DEBOUNCE_LEN);
  - the step encoding (STEP_NONE, STEP_UP, STEP_DN);
  - a saturating/wrapping add function.
- Sub-module enc_channel: synchroniser, two debouncers, decoder and level counter for one channel. It is instantiated NUM_CH times via generate.
- The PWM timebase and comparators stay in the top module.

Test Plan (NUM_CH=3, WIDTH=8, DEBOUNCE_LEN=4, SATURATE=1 unless stated):
- Reset, then five clean A pulses on ch0 with B=0 (each phase held 20 cycles) -> level_out[7:0]=5, others 0; first change exactly 8 edges after A is first sampled high.
- Ch1 level 0, one pulse with B=1 -> stays 0. Ch1 preloaded to 255 (or 255 pulses), one more up-pulse -> stays 255. With SATURATE=0: 255 plus up -> 0, and 0 plus down -> 255.
- 3-cycle high glitch on enc_a[2] -> no level change. 4-cycle stable high -> the debounced value changes.
- Ch0 level=64 -> pwm_out[0] high exactly 64 of every 256 cycles. Level changed to 128 mid-period -> old duty until pcnt wraps, then 128. Level 0 -> always low. Level 255 -> one low cycle per period.
- reset asserted for 1 cycle while levels are 10/20/30 and a debounce is in progress -> next cycle all levels 0, pwm_out=0, and the in-flight edge is lost.
- RGB_MIXER_LOAD_EN: load_ch=1, load_value=200 coincident with an up-step on ch1 -> level 200. load_ch=3 -> no change on any channel.
